// File: rtl/fsm_seq_ctrl.sv
// Sequencer that walks the protocol FSM through N IDLE->S1->S2->IDLE transactions,
// checks its {o1,o2,err} feedback and recovers it to IDLE with bounded retries.
module fsm_seq_ctrl #(
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3,
    parameter int RTY_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             abort,
    input  logic             fb_o1,
    input  logic             fb_o2,
    input  logic             fb_err,
    output logic             drv_i1,
    output logic             drv_i2,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] txn_done,
    output logic [RTY_W-1:0] retry_total
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RPT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        C_IDLE, GO1, CHK1, GO2, CHK2, GO3, CHK3, RCV_A, RCV_B, C_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] txn_done_q, txn_done_d;
    logic [RTY_W-1:0] retry_total_q, retry_total_d;
    logic             fail_q, fail_d;
    logic             quit_q, quit_d;
    logic [1:0]       drv_q, drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       fb;
    logic [2:0]       exp_fb;
    logic [CNT_W-1:0] txn_inc;
    logic             busy_now;
    logic             step_err;

    function automatic logic [RTY_W-1:0] sat_inc_rty(input logic [RTY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fb       = {fb_o1, fb_o2, fb_err};
    assign txn_inc  = txn_done_q + 1'b1;
    assign busy_now = (state_q != C_IDLE) && (state_q != C_DONE);

    always_comb begin
        exp_fb = 3'b000;
        case (state_q)
            CHK1:    exp_fb = 3'b100;
            CHK2:    exp_fb = 3'b010;
            default: exp_fb = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        rpt_d         = rpt_q;
        cnt_d         = cnt_q;
        txn_done_d    = txn_done_q;
        retry_total_d = retry_total_q;
        fail_d        = fail_q;
        quit_d        = quit_q;
        step_err      = 1'b0;

        // Abort wins over any same-cycle check result; the FSM is still recovered first.
        if (abort && busy_now) begin
            state_d = RCV_A;
            quit_d  = 1'b1;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (start) begin
                        cnt_d      = num_txn;
                        txn_done_d = '0;
                        rpt_d      = '0;
                        fail_d     = 1'b0;
                        quit_d     = 1'b0;
                        state_d    = (num_txn == '0) ? C_DONE : GO1;
                    end
                end
                GO1: begin
                    state_d = CHK1;
                    tmr_d   = '0;
                end
                GO2: begin
                    state_d = CHK2;
                    tmr_d   = '0;
                end
                GO3: begin
                    state_d = CHK3;
                    tmr_d   = '0;
                end
                CHK1, CHK2, CHK3: begin
                    if (fb == exp_fb) begin
                        if (state_q == CHK1) begin
                            state_d = GO2;
                        end else if (state_q == CHK2) begin
                            state_d = GO3;
                        end else begin
                            txn_done_d = txn_inc;
                            rpt_d      = '0;
                            if (txn_inc == cnt_q) begin
                                state_d = C_DONE;
                                fail_d  = 1'b0;
                            end else begin
                                state_d = GO1;
                            end
                        end
                    end else if (fb_err || (tmr_q == TMR_MAX)) begin
                        step_err = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                RCV_A: begin
                    state_d = RCV_B;
                    tmr_d   = '0;
                end
                RCV_B: begin
                    if (fb == 3'b000) begin
                        state_d = quit_q ? C_DONE : GO1;
                        fail_d  = quit_q;
                    end else if (tmr_q == TMR_MAX) begin
                        state_d = C_DONE;
                        fail_d  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                C_DONE:  state_d = C_IDLE;
                default: state_d = C_IDLE;
            endcase

            if (step_err) begin
                state_d = RCV_A;
                if (rpt_q < RPT_MAX) begin
                    rpt_d         = rpt_q + 1'b1;
                    retry_total_d = sat_inc_rty(retry_total_q);
                end else begin
                    quit_d = 1'b1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        drv_d = 2'b00;
        case (state_d)
            GO1, GO2: drv_d = 2'b11;
            CHK1:     drv_d = 2'b10;
            CHK2:     drv_d = 2'b01;
            GO3:      drv_d = 2'b10;
            RCV_A:    drv_d = 2'b01;
            default:  drv_d = 2'b00;
        endcase
        busy_d = (state_d != C_IDLE) && (state_d != C_DONE);
        done_d = (state_d == C_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= C_IDLE;
            tmr_q         <= '0;
            rpt_q         <= '0;
            cnt_q         <= '0;
            txn_done_q    <= '0;
            retry_total_q <= '0;
            fail_q        <= 1'b0;
            quit_q        <= 1'b0;
            drv_q         <= 2'b00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            rpt_q         <= rpt_d;
            cnt_q         <= cnt_d;
            txn_done_q    <= txn_done_d;
            retry_total_q <= retry_total_d;
            fail_q        <= fail_d;
            quit_q        <= quit_d;
            drv_q         <= drv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign drv_i1      = drv_q[1];
    assign drv_i2      = drv_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign txn_done    = txn_done_q;
    assign retry_total = retry_total_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl with a behavioural model of the protocol FSM
// (IDLE/S1/S2/ERROR) closing the feedback loop.
module tb_fsm_seq_ctrl;

    localparam int CNT_W = 8;
    localparam int RTY_W = 2;   // narrow so retry_total saturation is reachable quickly

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_txn;
    logic             abort;
    logic             fb_o1, fb_o2, fb_err;
    logic             drv_i1, drv_i2, busy, done, fail;
    logic [CNT_W-1:0] txn_done;
    logic [RTY_W-1:0] retry_total;

    int total = 0;
    int bad   = 0;

    logic [1:0] m_st;
    logic       force_err;
    logic       stuck;
    logic [1:0] exp6 [0:5] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};

    fsm_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(16), .MAX_RETRY(3), .RTY_W(RTY_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn), .abort(abort),
        .fb_o1(fb_o1), .fb_o2(fb_o2), .fb_err(fb_err),
        .drv_i1(drv_i1), .drv_i2(drv_i2), .busy(busy), .done(done), .fail(fail),
        .txn_done(txn_done), .retry_total(retry_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol FSM model: 0=IDLE 1=S1 2=S2 3=ERROR
    function automatic logic [1:0] m_next(input logic [1:0] s, input logic [1:0] d);
        case (s)
            2'd0: return (d == 2'b11) ? 2'd1 : 2'd0;
            2'd1: return (d == 2'b11) ? 2'd2 : (d == 2'b01) ? 2'd3 : 2'd1;
            2'd2: return (d == 2'b10) ? 2'd0 : (d == 2'b00) ? 2'd3 : 2'd2;
            default: return (d == 2'b00 || d == 2'b01) ? 2'd0 : 2'd3;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst)           m_st <= 2'd0;
        else if (force_err) m_st <= 2'd3;
        else                m_st <= m_next(m_st, {drv_i1, drv_i2});
    end

    always_comb begin
        {fb_o1, fb_o2, fb_err} = 3'b000;
        if (!stuck) begin
            case (m_st)
                2'd1:    {fb_o1, fb_o2, fb_err} = 3'b100;
                2'd2:    {fb_o1, fb_o2, fb_err} = 3'b010;
                2'd3:    {fb_o1, fb_o2, fb_err} = 3'b111;
                default: {fb_o1, fb_o2, fb_err} = 3'b000;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the caller at the negedge just after the start-accept edge (k=0).
    task automatic go(input logic [CNT_W-1:0] n);
        num_txn = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int k;
        logic [1:0] d16, d17;
        rst = 1'b0; start = 1'b0; num_txn = '0; abort = 1'b0;
        force_err = 1'b0; stuck = 1'b0;

        @(negedge clk);
        chk("rst_drv", {drv_i1, drv_i2}, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_txn", txn_done, 0);
        chk("rst_rty", retry_total, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: two fault-free transactions
        go(2);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_drv%0d", i), {drv_i1, drv_i2}, exp6[i % 6]);
            chk("t1_busy", busy, 1);
            chk("t1_nodone", done, 0);
            @(negedge clk);
        end
        chk("t1_done13", done, 1);
        chk("t1_fail", fail, 0);
        chk("t1_txn", txn_done, 2);
        chk("t1_rty", retry_total, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_drv_end", {drv_i1, drv_i2}, 2'b00);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_fail_hold", fail, 0);

        // 2: zero transactions
        go(0);
        chk("t2_done1", done, 1);
        chk("t2_fail", fail, 0);
        chk("t2_txn", txn_done, 0);
        chk("t2_drv", {drv_i1, drv_i2}, 2'b00);
        chk("t2_busy", busy, 0);
        @(negedge clk);
        chk("t2_done_pulse", done, 0);

        // 3: FSM forced into ERROR during CHK2, one retry
        go(1);
        @(negedge clk);
        @(negedge clk);
        force_err = 1'b1;
        @(negedge clk);
        force_err = 1'b0;
        @(negedge clk);
        chk("t3_rcva", {drv_i1, drv_i2}, 2'b01);
        chk("t3_rty_now", retry_total, 1);
        @(negedge clk);
        chk("t3_rcvb", {drv_i1, drv_i2}, 2'b00);
        @(negedge clk);
        chk("t3_rego", {drv_i1, drv_i2}, 2'b11);
        wait_done(40, c);
        chk("t3_lat", 6 + c, 12);
        chk("t3_fail", fail, 0);
        chk("t3_txn", txn_done, 1);
        chk("t3_rty", retry_total, 1);

        // 4: unresponsive FSM, timeouts exhaust retries
        do_reset();
        stuck = 1'b1;
        go(1);
        k = 0; d16 = 2'b00; d17 = 2'b00;
        while (done !== 1'b1 && k < 200) begin
            if (k == 16) d16 = {drv_i1, drv_i2};
            if (k == 17) d17 = {drv_i1, drv_i2};
            @(negedge clk);
            k++;
        end
        chk("t4_done_seen", done, 1);
        chk("t4_lat", k, 76);
        chk("t4_chk_last", d16, 2'b10);
        chk("t4_timeout", d17, 2'b01);
        chk("t4_fail", fail, 1);
        chk("t4_txn", txn_done, 0);
        chk("t4_rty", retry_total, 3);
        @(negedge clk);
        go(1);
        wait_done(200, c);
        chk("t4b_lat", c, 76);
        chk("t4b_fail", fail, 1);
        chk("t4b_rty_sat", retry_total, 3);
        stuck = 1'b0;
        @(negedge clk);

        // 5: abort during CHK2 with FSM in S2
        do_reset();
        go(1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_rcva", {drv_i1, drv_i2}, 2'b01);
        for (int i = 5; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t5_rcvb%0d", i), {drv_i1, drv_i2}, 2'b00);
            chk("t5_busy", busy, 1);
            chk("t5_nodone", done, 0);
        end
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_fail", fail, 1);
        start = 1'b1;
        num_txn = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_ign_busy", busy, 0);
        chk("t5_ign_done", done, 0);
        chk("t5_fail_hold", fail, 1);
        @(negedge clk);
        chk("t5_ign_busy2", busy, 0);
        chk("t5_ign_drv", {drv_i1, drv_i2}, 2'b00);

        // abort while idle is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_drv", {drv_i1, drv_i2}, 2'b00);

        // 6: asynchronous reset in GO2 of the second transaction
        go(2);
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("t6_pre_txn", txn_done, 1);
        chk("t6_pre_drv", {drv_i1, drv_i2}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("t6_drv", {drv_i1, drv_i2}, 2'b00);
        chk("t6_busy", busy, 0);
        chk("t6_txn", txn_done, 0);
        chk("t6_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_nodone", done, 0);
            chk("t6_idle", busy, 0);
        end
        go(1);
        wait_done(40, c);
        chk("t6_lat", c, 6);
        chk("t6_fail", fail, 0);
        chk("t6_txn_end", txn_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
